// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
// Ports: clk_i/rst_i, stall_i/flush_i, ID_* in, EX_* out, hazard/PC/IF_ID enables, bubble_cnt_o.
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            ID_RegWrite_i,
    input  logic            ID_MemtoReg_i,
    input  logic            ID_MemRead_i,
    input  logic            ID_MemWrite_i,
    input  logic            ID_ALUSrc_i,
    input  logic            ID_RegDst_i,
    input  logic [1:0]      ID_ALUOp_i,
    input  logic [DW-1:0]   ID_RSdata_i,
    input  logic [DW-1:0]   ID_RTdata_i,
    input  logic [DW-1:0]   ID_Imm_i,
    input  logic [4:0]      ID_RSaddr_i,
    input  logic [4:0]      ID_RTaddr_i,
    input  logic [4:0]      ID_RDaddr_i,
    output logic            EX_RegWrite_o,
    output logic            EX_MemtoReg_o,
    output logic            EX_MemRead_o,
    output logic            EX_MemWrite_o,
    output logic            EX_ALUSrc_o,
    output logic            EX_RegDst_o,
    output logic [1:0]      EX_ALUOp_o,
    output logic [DW-1:0]   EX_RSdata_o,
    output logic [DW-1:0]   EX_RTdata_o,
    output logic [DW-1:0]   EX_Imm_o,
    output logic [4:0]      EX_RSaddr_o,
    output logic [4:0]      EX_RTaddr_o,
    output logic [4:0]      EX_RDaddr_o,
    output logic            hazard_o,
    output logic            PCWrite_o,
    output logic            IF_ID_Write_o,
    output logic [CNTW-1:0] bubble_cnt_o
);

    typedef struct packed {
        logic          reg_write;
        logic          mem_to_reg;
        logic          mem_read;
        logic          mem_write;
        logic          alu_src;
        logic          reg_dst;
        logic [1:0]    alu_op;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    rs_addr;
        logic [4:0]    rt_addr;
        logic [4:0]    rd_addr;
    } id_ex_t;

    id_ex_t id_bus;
    id_ex_t ex_q;

    assign id_bus = '{
        reg_write:  ID_RegWrite_i,
        mem_to_reg: ID_MemtoReg_i,
        mem_read:   ID_MemRead_i,
        mem_write:  ID_MemWrite_i,
        alu_src:    ID_ALUSrc_i,
        reg_dst:    ID_RegDst_i,
        alu_op:     ID_ALUOp_i,
        rs_data:    ID_RSdata_i,
        rt_data:    ID_RTdata_i,
        imm:        ID_Imm_i,
        rs_addr:    ID_RSaddr_i,
        rt_addr:    ID_RTaddr_i,
        rd_addr:    ID_RDaddr_i
    };

    // A load writing $zero never creates a real dependency.
    assign hazard_o = ex_q.mem_read
                   && (ex_q.rt_addr != 5'd0)
                   && ((ex_q.rt_addr == ID_RSaddr_i)
                    || (ex_q.rt_addr == ID_RTaddr_i));

    assign PCWrite_o     = !hazard_o;
    assign IF_ID_Write_o = !hazard_o;

    // Bubbles clear addresses too, so forwarding never matches them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q <= '0;
        end else if (stall_i) begin
            ex_q <= ex_q;
        end else if (flush_i || hazard_o) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_bus;
        end
    end

    // Only load-use bubbles count; flush-only bubbles do not.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (!stall_i && hazard_o && (bubble_cnt_o != '1)) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

    assign EX_RegWrite_o = ex_q.reg_write;
    assign EX_MemtoReg_o = ex_q.mem_to_reg;
    assign EX_MemRead_o  = ex_q.mem_read;
    assign EX_MemWrite_o = ex_q.mem_write;
    assign EX_ALUSrc_o   = ex_q.alu_src;
    assign EX_RegDst_o   = ex_q.reg_dst;
    assign EX_ALUOp_o    = ex_q.alu_op;
    assign EX_RSdata_o   = ex_q.rs_data;
    assign EX_RTdata_o   = ex_q.rt_data;
    assign EX_Imm_o      = ex_q.imm;
    assign EX_RSaddr_o   = ex_q.rs_addr;
    assign EX_RTaddr_o   = ex_q.rt_addr;
    assign EX_RDaddr_o   = ex_q.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, load-use, flush, stall,
// reset and counter saturation (second instance with CNTW=2).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        i_rw, i_mtr, i_mr, i_mw, i_as, i_rdst;
    logic [1:0]  i_op;
    logic [31:0] i_rsd, i_rtd, i_imm;
    logic [4:0]  i_rs, i_rt, i_rd;

    logic        o_rw, o_mtr, o_mr, o_mw, o_as, o_rdst;
    logic [1:0]  o_op;
    logic [31:0] o_rsd, o_rtd, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        haz, pcw, ifw;
    logic [15:0] cnt;

    logic        s_rw, s_mtr, s_mr, s_mw, s_as, s_rdst;
    logic [1:0]  s_op;
    logic [31:0] s_rsd, s_rtd, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic        s_haz, s_pcw, s_ifw;
    logic [1:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    logic [22:0] ex_ctl;
    assign ex_ctl = {o_rw, o_mtr, o_mr, o_mw, o_as, o_rdst,
                     o_op, o_rs, o_rt, o_rd};

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .CNTW(16)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .ID_RegWrite_i(i_rw), .ID_MemtoReg_i(i_mtr),
        .ID_MemRead_i(i_mr), .ID_MemWrite_i(i_mw),
        .ID_ALUSrc_i(i_as), .ID_RegDst_i(i_rdst), .ID_ALUOp_i(i_op),
        .ID_RSdata_i(i_rsd), .ID_RTdata_i(i_rtd), .ID_Imm_i(i_imm),
        .ID_RSaddr_i(i_rs), .ID_RTaddr_i(i_rt), .ID_RDaddr_i(i_rd),
        .EX_RegWrite_o(o_rw), .EX_MemtoReg_o(o_mtr),
        .EX_MemRead_o(o_mr), .EX_MemWrite_o(o_mw),
        .EX_ALUSrc_o(o_as), .EX_RegDst_o(o_rdst), .EX_ALUOp_o(o_op),
        .EX_RSdata_o(o_rsd), .EX_RTdata_o(o_rtd), .EX_Imm_o(o_imm),
        .EX_RSaddr_o(o_rs), .EX_RTaddr_o(o_rt), .EX_RDaddr_o(o_rd),
        .hazard_o(haz), .PCWrite_o(pcw), .IF_ID_Write_o(ifw),
        .bubble_cnt_o(cnt)
    );

    id_ex_stage #(.DW(32), .CNTW(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .ID_RegWrite_i(i_rw), .ID_MemtoReg_i(i_mtr),
        .ID_MemRead_i(i_mr), .ID_MemWrite_i(i_mw),
        .ID_ALUSrc_i(i_as), .ID_RegDst_i(i_rdst), .ID_ALUOp_i(i_op),
        .ID_RSdata_i(i_rsd), .ID_RTdata_i(i_rtd), .ID_Imm_i(i_imm),
        .ID_RSaddr_i(i_rs), .ID_RTaddr_i(i_rt), .ID_RDaddr_i(i_rd),
        .EX_RegWrite_o(s_rw), .EX_MemtoReg_o(s_mtr),
        .EX_MemRead_o(s_mr), .EX_MemWrite_o(s_mw),
        .EX_ALUSrc_o(s_as), .EX_RegDst_o(s_rdst), .EX_ALUOp_o(s_op),
        .EX_RSdata_o(s_rsd), .EX_RTdata_o(s_rtd), .EX_Imm_o(s_imm),
        .EX_RSaddr_o(s_rs), .EX_RTaddr_o(s_rt), .EX_RDaddr_o(s_rd),
        .hazard_o(s_haz), .PCWrite_o(s_pcw), .IF_ID_Write_o(s_ifw),
        .bubble_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [7:0] ctl, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm);
        {i_rw, i_mtr, i_mr, i_mw, i_as, i_rdst, i_op} = ctl;
        i_rs  = rs;
        i_rt  = rt;
        i_rd  = rd;
        i_rsd = rsd;
        i_rtd = rtd;
        i_imm = imm;
        #1;
    endtask

    // ctl = {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp}
    localparam logic [7:0] C_ALU  = 8'b1000_0110;
    localparam logic [7:0] C_LOAD = 8'b1110_1000;
    localparam logic [7:0] C_ALL  = 8'b1111_1111;

    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        drv(8'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #12;
        rst = 1'b1;
        step();

        // capture all-ones then reset asynchronously mid-cycle
        drv(C_ALL, 5'd31, 5'd30, 5'd29, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'hFFFF_FFFD);
        step();
        chk("all_ones_ctl", ex_ctl, {8'hFF, 5'd31, 5'd30, 5'd29});
        chk("all_ones_imm", o_imm, 32'hFFFF_FFFD);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ctl", ex_ctl, 23'd0);
        chk("rst_data", {o_rsd, o_rtd}, 64'd0);
        chk("rst_imm", o_imm, 32'd0);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_en", {haz, pcw, ifw}, 3'b011);
        rst = 1'b1;
        step();

        // normal capture
        drv(C_ALU, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33);
        step();
        chk("cap_ctl", ex_ctl, {C_ALU, 5'd3, 5'd4, 5'd5});
        chk("cap_data", {o_rsd, o_rtd}, {32'h11, 32'h22});
        chk("cap_imm", o_imm, 32'h33);
        chk("cap_pcw", pcw, 1'b1);

        // load-use on RS
        drv(C_LOAD, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4);
        step();
        chk("ld_ctl", ex_ctl, {C_LOAD, 5'd1, 5'd8, 5'd0});
        drv(C_ALU, 5'd8, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'hCC);
        chk("lu_en", {haz, pcw, ifw}, 3'b100);
        step();
        chk("lu_bub_ctl", ex_ctl, 23'd0);
        chk("lu_bub_data", {o_rsd, o_rtd}, 64'd0);
        chk("lu_bub_imm", o_imm, 32'd0);
        chk("lu_cnt", cnt, 16'd1);
        chk("lu_clear", {haz, pcw, ifw}, 3'b011);
        step();
        chk("lu_dep_ctl", ex_ctl, {C_ALU, 5'd8, 5'd2, 5'd9});
        chk("lu_dep_data", o_rsd, 32'hAA);
        chk("lu_cnt_hold", cnt, 16'd1);

        // $zero target never hazards
        drv(C_LOAD, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        drv(C_ALU, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0);
        chk("zero_haz", {o_mr, haz}, 2'b10);

        // no address match
        drv(C_LOAD, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        drv(C_ALU, 5'd9, 5'd10, 5'd7, 32'h0, 32'h0, 32'h0);
        chk("nomatch_haz", haz, 1'b0);

        // match on RT
        drv(C_ALU, 5'd9, 5'd8, 5'd7, 32'h0, 32'h0, 32'h0);
        chk("rt_haz", haz, 1'b1);
        step();
        chk("rt_cnt", cnt, 16'd2);
        chk("rt_bub", ex_ctl, 23'd0);

        // flush only: bubble without counting
        drv(C_ALU, 5'd3, 5'd4, 5'd5, 32'h55, 32'h66, 32'h77);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_ctl", ex_ctl, 23'd0);
        chk("fl_data", {o_rsd, o_imm}, 64'd0);
        chk("fl_cnt", cnt, 16'd2);

        // flush with hazard: single bubble, counted
        drv(C_LOAD, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        drv(C_ALU, 5'd8, 5'd4, 5'd5, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flhz_haz", haz, 1'b1);
        step();
        flush = 1'b0;
        chk("flhz_ctl", ex_ctl, 23'd0);
        chk("flhz_cnt", cnt, 16'd3);

        // stall freezes contents while ID changes
        drv(C_ALU, 5'd6, 5'd7, 5'd11, 32'h66, 32'h77, 32'h88);
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv(C_ALL, 5'(k + 20), 5'(k + 21), 5'(k + 22),
                32'(k), 32'(k), 32'(k));
            step();
            chk("st_ctl", ex_ctl, {C_ALU, 5'd6, 5'd7, 5'd11});
            chk("st_data", o_rsd, 32'h66);
        end
        stall = 1'b0;

        // stall during a hazard keeps it asserted
        drv(C_LOAD, 5'd1, 5'd12, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        stall = 1'b1;
        drv(C_ALU, 5'd12, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sthz_en", {haz, pcw, ifw, o_mr}, 4'b1001);
            chk("sthz_cnt", cnt, 16'd3);
        end
        stall = 1'b0;
        step();
        chk("sthz_bub", ex_ctl, 23'd0);
        chk("sthz_cnt2", cnt, 16'd4);

        // saturation on the CNTW=2 instance
        #2;
        rst = 1'b0;
        #1;
        chk("sat_rst", {s_cnt, cnt}, 18'd0);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drv(C_LOAD, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0);
            step();
            drv(C_ALU, 5'd8, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0);
            step();
            chk("sat_cnt", s_cnt, sat_exp[k]);
            chk("wide_cnt", cnt, 16'(k + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
